activation_row_feeder: RTL and testbench

Producer side of the 3×3 sliding-window activation register file. Accepts one feature-map channel as a raster-order pixel stream and buffers the previous two rows. It drives `data_first_row`/`data_second_row`/`data_third_row` plus `act_load` so the window register file shifts in one vertically aligned 3-pixel column per load, with 1-pixel zero padding on all four sides (VGG "same" convolution). It sits between the activation SRAM reader and the window register file.

---
 rtl/activation_row_feeder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_activation_row_feeder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_row_feeder.sv
// ---------------------------------------------------------------------------
// activation_row_feeder
//
// Producer side of the 3x3 sliding-window activation register file. Takes a
// single feature-map channel as a raster-order pixel stream, keeps the two
// previous rows in line buffers, and emits one vertically aligned 3-pixel
// column per act_load so the window register file can shift it in. The frame
// is zero padded by one pixel on every side ("same" convolution).
//
// Ports:
//   clk, rst_n       - single clock, synchronous active-low reset
//   start            - frame start, only honoured while idle
//   img_width        - W, latched on an accepted start (1..MAX_WIDTH)
//   img_height       - H, latched on an accepted start (>= 1)
//   in_valid/in_data - raster-order pixel stream from the activation SRAM
//   in_ready         - feeder takes a pixel this cycle (FILL and BODY only)
//   data_*_row       - top/middle/bottom pixel of the column (registered)
//   act_load         - shift strobe to the window register file (registered)
//   patch_valid      - window register file holds a full patch this cycle
//   out_row/out_col  - centre coordinate of that patch
//   busy             - frame in progress (up to and excluding the done cycle)
//   done             - one-cycle pulse with the last patch_valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module activation_row_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 224,
    parameter int DIM_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_W-1:0]      img_width,
    input  logic [DIM_W-1:0]      img_height,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_first_row,
    output logic [DATA_WIDTH-1:0] data_second_row,
    output logic [DATA_WIDTH-1:0] data_third_row,
    output logic                  act_load,
    output logic                  patch_valid,
    output logic [DIM_W-1:0]      out_row,
    output logic [DIM_W-1:0]      out_col,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DIM_W:0]   MAX_W_EXT = MAX_WIDTH[DIM_W:0];
    localparam logic [DIM_W-1:0] DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD_L,
        BODY,
        PAD_R,
        FLUSH_L,
        FLUSH_BODY,
        FLUSH_R
    } state_t;

    state_t state;

    // Latched frame geometry (stored as W-1 / H-1 so compares are direct)
    logic [DIM_W-1:0] w_m1;
    logic [DIM_W-1:0] h_m1;

    // col walks the unpadded columns of the row being consumed or flushed;
    // row_cnt is the output row currently being emitted.
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row_cnt;

    // Line buffers: B holds row i-1, A holds row i-2. Never reset.
    logic [DATA_WIDTH-1:0] line_a [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] line_b [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] rd_first;

    logic handshake;
    logic start_ok;

    // Load being issued this cycle, before the output register stage
    logic                  issue_load;
    logic [DATA_WIDTH-1:0] issue_first;
    logic [DATA_WIDTH-1:0] issue_second;
    logic [DATA_WIDTH-1:0] issue_third;
    logic                  issue_pv;
    logic [DIM_W-1:0]      issue_col;
    logic                  issue_last;

    // Stage aligned with act_load; patch_valid follows one cycle later
    logic                  s1_pv;
    logic                  s1_last;
    logic [DIM_W-1:0]      s1_row;
    logic [DIM_W-1:0]      s1_col;

    assign in_ready  = (state == FILL) || (state == BODY);
    assign handshake = in_valid && in_ready;

    // busy stays high until the done cycle, so a start is refused while the
    // last patches drain even though the FSM has already returned to IDLE.
    assign start_ok = start && !busy && (state == IDLE) &&
                      (img_width != '0) &&
                      ({1'b0, img_width} <= MAX_W_EXT) &&
                      (img_height != '0);

    assign rd_a = line_a[col];
    assign rd_b = line_b[col];

    // Output row 0 has padding above it; A is stale there (and after a reset)
    assign rd_first = (row_cnt == '0) ? '0 : rd_a;

    // Decide what column (if any) goes to the window register file this
    // cycle. Pads issue zeros; BODY only loads on a handshake; FLUSH_BODY
    // replays the last two rows against a zero bottom row. The padded
    // column p = col+1 produces a patch when p >= 2, i.e. col >= 1, and the
    // right pad closes the row with the patch at column W-1.
    always_comb begin
        issue_load   = 1'b0;
        issue_first  = '0;
        issue_second = '0;
        issue_third  = '0;
        issue_pv     = 1'b0;
        issue_col    = '0;
        issue_last   = 1'b0;
        case (state)
            PAD_L, FLUSH_L: begin
                issue_load = 1'b1;
            end
            BODY: begin
                if (handshake) begin
                    issue_load   = 1'b1;
                    issue_first  = rd_first;
                    issue_second = rd_b;
                    issue_third  = in_data;
                    issue_pv     = (col != '0);
                    issue_col    = col - DIM_ONE;
                end
            end
            PAD_R: begin
                issue_load = 1'b1;
                issue_pv   = 1'b1;
                issue_col  = w_m1;
            end
            FLUSH_BODY: begin
                issue_load   = 1'b1;
                issue_first  = rd_first;
                issue_second = rd_b;
                issue_pv     = (col != '0);
                issue_col    = col - DIM_ONE;
            end
            FLUSH_R: begin
                issue_load = 1'b1;
                issue_pv   = 1'b1;
                issue_col  = w_m1;
                issue_last = 1'b1;
            end
            default: begin
                issue_load = 1'b0;
            end
        endcase
    end

    // Line buffer update: every accepted pixel lands in B, and in BODY the
    // previous contents of B at that column shift down into A.
    always_ff @(posedge clk) begin
        if (handshake) begin
            if (state == BODY) begin
                line_a[col] <= rd_b;
            end
            line_b[col] <= in_data;
        end
    end

    // Frame sequencer. Each output row is PAD_L, W body columns, PAD_R; the
    // last output row is produced from the buffers alone in the FLUSH states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            w_m1    <= '0;
            h_m1    <= '0;
            col     <= '0;
            row_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            if (s1_last) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        w_m1    <= img_width - DIM_ONE;
                        h_m1    <= img_height - DIM_ONE;
                        col     <= '0;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (handshake) begin
                        if (col == w_m1) begin
                            col   <= '0;
                            state <= (h_m1 != '0) ? PAD_L : FLUSH_L;
                        end else begin
                            col <= col + DIM_ONE;
                        end
                    end
                end
                PAD_L: begin
                    state <= BODY;
                end
                BODY: begin
                    if (handshake) begin
                        if (col == w_m1) begin
                            col   <= '0;
                            state <= PAD_R;
                        end else begin
                            col <= col + DIM_ONE;
                        end
                    end
                end
                PAD_R: begin
                    // The next output row is the last one once input row
                    // H-1 has been consumed, and that row comes from flush.
                    row_cnt <= row_cnt + DIM_ONE;
                    state   <= ((row_cnt + DIM_ONE) == h_m1) ? FLUSH_L : PAD_L;
                end
                FLUSH_L: begin
                    state <= FLUSH_BODY;
                end
                FLUSH_BODY: begin
                    if (col == w_m1) begin
                        col   <= '0;
                        state <= FLUSH_R;
                    end else begin
                        col <= col + DIM_ONE;
                    end
                end
                FLUSH_R: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output registers. act_load and the column data appear one cycle after
    // the issue; patch_valid/out_row/out_col/done one cycle after that, when
    // the window register file has actually shifted the column in. The data
    // outputs hold their value on cycles without a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_load        <= 1'b0;
            data_first_row  <= '0;
            data_second_row <= '0;
            data_third_row  <= '0;
            s1_pv           <= 1'b0;
            s1_last         <= 1'b0;
            s1_row          <= '0;
            s1_col          <= '0;
            patch_valid     <= 1'b0;
            out_row         <= '0;
            out_col         <= '0;
            done            <= 1'b0;
        end else begin
            act_load <= issue_load;
            if (issue_load) begin
                data_first_row  <= issue_first;
                data_second_row <= issue_second;
                data_third_row  <= issue_third;
            end
            s1_pv   <= issue_pv;
            s1_last <= issue_last;
            s1_row  <= row_cnt;
            s1_col  <= issue_col;

            patch_valid <= s1_pv;
            done        <= s1_last;
            if (s1_pv) begin
                out_row <= s1_row;
                out_col <= s1_col;
            end
        end
    end

endmodule

// File: tb/tb_activation_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_activation_row_feeder
//
// Self-checking bench for activation_row_feeder. A negedge monitor records
// every act_load column and every patch; each test task builds the expected
// sequence from the padded-image definition (pixel at (r,c), zero outside
// the frame) and compares the recorded traffic against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_activation_row_feeder;

    localparam int DW   = 16;
    localparam int MAXW = 224;
    localparam int DIMW = 8;
    localparam int BANK = MAXW * 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [DIMW-1:0] img_width;
    logic [DIMW-1:0] img_height;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [DW-1:0]   data_first_row;
    logic [DW-1:0]   data_second_row;
    logic [DW-1:0]   data_third_row;
    logic            act_load;
    logic            patch_valid;
    logic [DIMW-1:0] out_row;
    logic [DIMW-1:0] out_col;
    logic            busy;
    logic            done;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle        = 0;
    int k0           = 0;

    // Pixel storage: two banks so a chained frame can be prepared up front
    logic [DW-1:0] pix [0:2*BANK-1];

    logic [3*DW-1:0] exp_load[$];
    logic [15:0]     exp_patch[$];
    logic [3*DW-1:0] obs_load[$];
    logic [15:0]     obs_patch[$];
    int obs_done_cnt   = 0;
    int obs_done_idx   = -1;
    int obs_done_cycle = -1;
    int obs_stray_done = 0;

    activation_row_feeder #(
        .DATA_WIDTH(DW),
        .MAX_WIDTH (MAXW),
        .DIM_W     (DIMW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .img_width      (img_width),
        .img_height     (img_height),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .data_first_row (data_first_row),
        .data_second_row(data_second_row),
        .data_third_row (data_third_row),
        .act_load       (act_load),
        .patch_valid    (patch_valid),
        .out_row        (out_row),
        .out_col        (out_col),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record all window traffic away from the active edge
    always @(negedge clk) begin
        if (act_load === 1'b1) begin
            obs_load.push_back({data_first_row, data_second_row, data_third_row});
        end
        if (patch_valid === 1'b1) begin
            obs_patch.push_back({out_row, out_col});
            if (done === 1'b1) obs_done_idx = obs_patch.size() - 1;
        end
        if (done === 1'b1) begin
            obs_done_cnt++;
            obs_done_cycle = cycle;
            if (patch_valid !== 1'b1) obs_stray_done++;
        end
    end

    // Padded image: zero outside the W x H frame
    function automatic logic [DW-1:0] pix_at(input int base, input int w, input int h,
                                             input int r, input int c);
        if (r < 0 || r >= h || c < 0 || c >= w) return '0;
        return pix[base + r * w + c];
    endfunction

    // Each output row r is W+2 padded columns; column p shows rows r-1..r+1
    // at image column p-1, and patches exist for p >= 2 centred on p-2.
    task automatic build_model(input int base, input int w, input int h);
        exp_load.delete();
        exp_patch.delete();
        for (int r = 0; r < h; r++) begin
            for (int p = 0; p < w + 2; p++) begin
                exp_load.push_back({pix_at(base, w, h, r - 1, p - 1),
                                    pix_at(base, w, h, r,     p - 1),
                                    pix_at(base, w, h, r + 1, p - 1)});
                if (p >= 2) exp_patch.push_back({8'(r), 8'(p - 2)});
            end
        end
    endtask

    task automatic fill_bank(input int base, input int n, input int ramp, input int first);
        for (int i = 0; i < n; i++) begin
            pix[base + i] = (ramp != 0) ? 16'(first + i) : 16'($urandom);
        end
    endtask

    task automatic start_frame(input int w, input int h);
        start      = 1'b1;
        img_width  = 8'(w);
        img_height = 8'(h);
        k0         = cycle;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: valid always high, 1: valid on every third cycle, 2: random
    task automatic feed(input int base, input int mode, input int count, output int fed);
        int idx;
        int cyc;
        logic hs;
        idx = 0;
        cyc = 0;
        while (idx < count && cyc < 20000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc % 3) == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? pix[base + idx] : 16'($urandom);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        fed = idx;
    endtask

    task automatic test_reset();
        logic [68:0] snap;
        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        img_width  = '0;
        img_height = '0;
        repeat (3) @(posedge clk);
        #1;
        snap = {in_ready, act_load, patch_valid, busy, done, out_row, out_col,
                data_first_row, data_second_row, data_third_row};
        n_compared++;
        if (snap !== 69'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", snap);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_compared++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: busy=%b in_ready=%b expected 0/0", busy, in_ready);
        end
    endtask

    // One complete frame: optional noisy start while busy, optional chained
    // start in the done cycle (next_w > 0), or entry with the frame already
    // started by the previous call (started != 0).
    task automatic test_frame(input string name, input int base, input int w, input int h,
                              input int mode, input int noisy, input int started,
                              input int next_w, input int next_h);
        int lb;
        int pb;
        int db;
        int fed;
        int cyc;
        int k_start;
        lb = obs_load.size();
        pb = obs_patch.size();
        db = obs_done_cnt;
        build_model(base, w, h);
        if (started == 0) begin
            start_frame(w, h);
            n_compared++;
            if (busy !== 1'b1 || in_ready !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL %s start_resp: busy=%b in_ready=%b expected 1/1", name, busy, in_ready);
            end
        end
        k_start = k0;
        if (noisy != 0) begin
            start      = 1'b1;
            img_width  = 8'(w + 2);
            img_height = 8'(h + 1);
        end
        feed(base, mode, w * h, fed);
        start = 1'b0;
        n_compared++;
        if (fed != w * h) begin
            n_mismatched++;
            $display("[TB] FAIL %s feed: accepted %0d pixels expected %0d", name, fed, w * h);
        end
        if (next_w > 0) begin
            cyc = 0;
            while (done !== 1'b1 && cyc < 3000) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            n_compared++;
            if (done !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL %s chain_done: done=%b expected 1", name, done);
            end
            n_compared++;
            if (busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL %s busy_at_done: busy=%b expected 0", name, busy);
            end
            start_frame(next_w, next_h);
            n_compared++;
            if (busy !== 1'b1 || in_ready !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL %s restart_gap: busy=%b in_ready=%b expected 1/1", name, busy, in_ready);
            end
        end else begin
            cyc = 0;
            while (obs_done_cnt == db && cyc < 3000) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            repeat (3) @(posedge clk);
            #1;
            n_compared++;
            if (busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL %s busy_after: busy=%b expected 0", name, busy);
            end
        end
        n_compared++;
        if (obs_done_cnt != db + 1) begin
            n_mismatched++;
            $display("[TB] FAIL %s done_count: got %0d expected 1", name, obs_done_cnt - db);
        end
        n_compared++;
        if (obs_load.size() - lb != exp_load.size()) begin
            n_mismatched++;
            $display("[TB] FAIL %s load_count: got %0d expected %0d", name, obs_load.size() - lb, exp_load.size());
        end
        for (int i = 0; i < exp_load.size() && lb + i < obs_load.size(); i++) begin
            n_compared++;
            if (obs_load[lb + i] !== exp_load[i]) begin
                n_mismatched++;
                $display("[TB] FAIL %s load[%0d]: got %h expected %h", name, i, obs_load[lb + i], exp_load[i]);
            end
        end
        n_compared++;
        if (obs_patch.size() - pb != exp_patch.size()) begin
            n_mismatched++;
            $display("[TB] FAIL %s patch_count: got %0d expected %0d", name, obs_patch.size() - pb, exp_patch.size());
        end
        for (int i = 0; i < exp_patch.size() && pb + i < obs_patch.size(); i++) begin
            n_compared++;
            if (obs_patch[pb + i] !== exp_patch[i]) begin
                n_mismatched++;
                $display("[TB] FAIL %s patch[%0d]: got row/col %h expected %h", name, i, obs_patch[pb + i], exp_patch[i]);
            end
        end
        n_compared++;
        if (obs_done_idx != pb + exp_patch.size() - 1) begin
            n_mismatched++;
            $display("[TB] FAIL %s done_align: done at patch %0d expected %0d", name, obs_done_idx - pb, exp_patch.size() - 1);
        end
        if (mode == 0) begin
            n_compared++;
            if (obs_done_cycle - k_start != w + h * (w + 2) + 2) begin
                n_mismatched++;
                $display("[TB] FAIL %s latency: done %0d cycles after start expected %0d", name,
                         obs_done_cycle - k_start, w + h * (w + 2) + 2);
            end
        end
    endtask

    task automatic test_illegal_start();
        int ws[3] = '{0, MAXW + 1, 3};
        int hs[3] = '{3, 3, 0};
        for (int i = 0; i < 3; i++) begin
            start      = 1'b1;
            img_width  = 8'(ws[i]);
            img_height = 8'(hs[i]);
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int j = 0; j < 2; j++) begin
                n_compared++;
                if (busy !== 1'b0 || in_ready !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL illegal_start W=%0d H=%0d: busy=%b in_ready=%b expected 0/0",
                             ws[i], hs[i], busy, in_ready);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int fed;
        int db;
        logic [68:0] snap;
        fill_bank(0, 9, 1, 1);
        start_frame(3, 3);
        feed(0, 0, 5, fed);
        n_compared++;
        if (fed != 5) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_feed: accepted %0d expected 5", fed);
        end
        db = obs_done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap = {in_ready, act_load, patch_valid, busy, done, out_row, out_col,
                data_first_row, data_second_row, data_third_row};
        n_compared++;
        if (snap !== 69'd0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", snap);
        end
        repeat (6) @(posedge clk);
        #1;
        n_compared++;
        if (obs_done_cnt != db || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_idle: done_pulses=%0d busy=%b in_ready=%b expected 0/0/0",
                     obs_done_cnt - db, busy, in_ready);
        end
        test_frame("after_reset", 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random_frames();
        int w;
        int h;
        int m;
        for (int t = 0; t < 4; t++) begin
            w = int'($urandom_range(1, 12));
            h = int'($urandom_range(1, 6));
            m = ($urandom_range(0, 1) == 1) ? 2 : 0;
            fill_bank(0, w * h, 0, 0);
            test_frame("random", 0, w, h, m, 0, 0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        fill_bank(0, MAXW * 4, 1, int'($urandom_range(0, 1000)));
        fill_bank(BANK, 6 * 3, 0, 0);
        test_frame("full_width", 0, MAXW, 4, 0, 0, 0, 6, 3);
        test_frame("chained", BANK, 6, 3, 2, 0, 1, 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();

        fill_bank(0, 9, 1, 1);
        test_frame("frame_3x3", 0, 3, 3, 0, 0, 0, 0, 0);

        fill_bank(0, 4, 1, 5);
        test_frame("single_row", 0, 4, 1, 0, 0, 0, 0, 0);

        fill_bank(0, 9, 1, 1);
        test_frame("backpressure", 0, 3, 3, 1, 0, 0, 0, 0);

        test_illegal_start();

        fill_bank(0, 9, 0, 0);
        test_frame("start_while_busy", 0, 3, 3, 0, 1, 0, 0, 0);

        test_reset_mid_frame();
        test_random_frames();
        test_back_to_back();

        n_compared++;
        if (obs_stray_done != 0) begin
            n_mismatched++;
            $display("[TB] FAIL stray_done: %0d done pulses without patch_valid expected 0", obs_stray_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
